// File: rtl/key_debounce_repeat_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encodings, 50 MHz default timings and a small sizing helper.
package key_pkg;

  // Debouncer / auto-repeat FSM states. Encodings 5..7 are unused.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } key_state_e;

  // Default timings for CLOCK_50.
  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF  = CLK_HZ / 50;  // 20 ms
  localparam int unsigned REPEAT_DELAY_DEF     = CLK_HZ / 2;   // 0.5 s
  localparam int unsigned REPEAT_PERIOD_DEF    = CLK_HZ / 10;  // 0.1 s

  // Largest of three timing constants; sizes the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_repeat_if.sv
// Key-side bundle: raw key in, debounced level and event pulses out.
interface key_debounce_repeat_if;
  logic key_n;          // raw key, active-low, asynchronous
  logic pressed;        // debounced level, 1 = pressed
  logic press_pulse;    // one cycle on accepted press
  logic release_pulse;  // one cycle on accepted release
  logic step_pulse;     // one cycle on press and on each auto-repeat

  // Whoever owns the physical key.
  modport master (
    output key_n,
    input  pressed, press_pulse, release_pulse, step_pulse
  );

  // The conditioning block.
  modport slave (
    input  key_n,
    output pressed, press_pulse, release_pulse, step_pulse
  );
endinterface

// File: rtl/key_debounce_repeat_sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous inputs (keys,
// switches). Both stages reset to RESET_VALUE so a released input does not
// look active while reset is lifting.
module sync_2ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      sync <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments so sync takes the old meta value,
      // forming two real stages instead of collapsing into one.
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: synchronises an active-low key, debounces press
// and release with one shared counter, and produces registered level and
// single-cycle press / release / step pulses, with optional auto-repeat.
module key_debounce_repeat
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,  // >= 1
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,     // >= 2
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,    // >= 1
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  aclr,
  key_debounce_repeat_if.slave  kif
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             key_sync;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt, release_evt, step_evt;
  logic             press_evt_q, release_evt_q, step_evt_q;

  // The released level is 1 on key_n, so the synchroniser resets to 1.
  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (aclr),
    .d     (kif.key_n),
    .q     (key_sync)
  );

  assign key_s = ~key_sync;

  // Next state, counter and events; cnt_d defaults to 0 so any state change
  // clears the counter.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = '0;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    step_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d   = HELD;
          press_evt = 1'b1;
          step_evt  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
        end else if (REPEAT_EN) begin
          if (cnt_q == RD_LAST) begin
            state_d  = REPEAT;
            step_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
        end else if (cnt_q == RP_LAST) begin
          step_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_RELEASE: begin
        // A bounce back to pressed restarts the repeat delay in HELD.
        if (key_s) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d     = IDLE;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and event capture.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;
      step_evt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_evt_q   <= press_evt;
      release_evt_q <= release_evt;
      step_evt_q    <= step_evt;
    end
  end

  // Output stage: pulses land in the cycle after the transition, the same
  // cycle in which the registered level changes.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      kif.pressed       <= 1'b0;
      kif.press_pulse   <= 1'b0;
      kif.release_pulse <= 1'b0;
      kif.step_pulse    <= 1'b0;
    end else begin
      kif.pressed       <= (state_q inside {HELD, REPEAT, DB_RELEASE});
      kif.press_pulse   <= press_evt_q;
      kif.release_pulse <= release_evt_q;
      kif.step_pulse    <= step_evt_q;
    end
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: two instances (auto-repeat off / on) share
// one key and reset. A timeline model predicts every output per edge from
// the debounce/repeat rules; directed checks cover latencies and counts.
module tb_key_debounce_repeat;

  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 3;
  localparam int N = 4096;

  logic clk   = 1'b0;
  logic aclr  = 1'b0;
  logic key_n = 1'b1;

  always #5 clk = ~clk;

  key_debounce_repeat_if kif0 ();
  key_debounce_repeat_if kif1 ();
  assign kif0.key_n = key_n;
  assign kif1.key_n = key_n;

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (R),
    .REPEAT_PERIOD   (P),
    .REPEAT_EN       (1'b0)
  ) dut0 (
    .clk  (clk),
    .aclr (aclr),
    .kif  (kif0)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (R),
    .REPEAT_PERIOD   (P),
    .REPEAT_EN       (1'b1)
  ) dut1 (
    .clk  (clk),
    .aclr (aclr),
    .kif  (kif1)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int e      = 0;      // index of the last clock edge
  int start_edge;      // first edge sampling the current drive() value

  // Model: expected outputs per edge, per instance (0 = no repeat).
  bit exp_prs [2][N];
  bit exp_prp [2][N];
  bit exp_rlp [2][N];
  bit exp_stp [2][N];
  bit lvl [2];         // accepted key level
  int run [2];         // consecutive samples disagreeing with lvl
  int next_step [2];   // edge of the next auto-repeat pulse, -1 if none

  // Observed statistics for directed checks.
  int n_press [2];
  int n_rel   [2];
  int n_step  [2];
  int first_press [2];
  int first_rel   [2];
  bit rel_pressed [2];
  bit ever_pressed [2];
  bit all_pressed  [2];
  int step_at1 [$];

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, expv, e);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      lvl[m]       = 1'b0;
      run[m]       = 0;
      next_step[m] = -1;
      for (int i = e + 1; i <= e + 12; i++) begin
        exp_prs[m][i] = 1'b0;
        exp_prp[m][i] = 1'b0;
        exp_rlp[m][i] = 1'b0;
        exp_stp[m][i] = 1'b0;
      end
    end
  endfunction

  // A level change is accepted after D+1 consecutive disagreeing samples and
  // shows on the outputs 3 edges after the last of them. Repeats follow
  // R+1 edges after (re)entering the held condition, then every P edges.
  function automatic void model_edge(input int m, input bit sample);
    bit rep;
    bit mism;
    rep  = (m == 1);
    mism = ((sample == 1'b0) != lvl[m]);
    if (next_step[m] == e + 2) begin
      exp_stp[m][e + 2] = 1'b1;
      next_step[m] += P;
    end
    if (mism) begin
      if (lvl[m] && run[m] == 0) next_step[m] = -1;
      run[m]++;
      if (run[m] == D + 1) begin
        run[m] = 0;
        if (!lvl[m]) begin
          lvl[m] = 1'b1;
          exp_prp[m][e + 3] = 1'b1;
          exp_stp[m][e + 3] = 1'b1;
          next_step[m] = rep ? e + 3 + R : -1;
        end else begin
          lvl[m] = 1'b0;
          exp_rlp[m][e + 3] = 1'b1;
        end
      end
    end else begin
      if (lvl[m] && run[m] > 0) next_step[m] = rep ? e + 3 + R : -1;
      run[m] = 0;
    end
    exp_prs[m][e + 3] = lvl[m];
  endfunction

  function automatic void clear_stats();
    for (int m = 0; m < 2; m++) begin
      n_press[m] = 0; n_rel[m] = 0; n_step[m] = 0;
      first_press[m] = -1; first_rel[m] = -1;
      rel_pressed[m] = 1'b1; ever_pressed[m] = 1'b0; all_pressed[m] = 1'b1;
    end
    step_at1.delete();
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".dut0.pressed"}, kif0.pressed, 1'b0);
    chk({tag, ".dut0.press"},   kif0.press_pulse, 1'b0);
    chk({tag, ".dut0.release"}, kif0.release_pulse, 1'b0);
    chk({tag, ".dut0.step"},    kif0.step_pulse, 1'b0);
    chk({tag, ".dut1.pressed"}, kif1.pressed, 1'b0);
    chk({tag, ".dut1.press"},   kif1.press_pulse, 1'b0);
    chk({tag, ".dut1.release"}, kif1.release_pulse, 1'b0);
    chk({tag, ".dut1.step"},    kif1.step_pulse, 1'b0);
  endtask

  // One clock edge: advance the model, then compare every output 1 ns later.
  task automatic tick();
    logic [3:0] o;
    @(posedge clk);
    e++;
    if (aclr) begin
      model_edge(0, key_n);
      model_edge(1, key_n);
    end else begin
      model_reset();
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      o = (m == 0) ? {kif0.pressed, kif0.press_pulse, kif0.release_pulse, kif0.step_pulse}
                   : {kif1.pressed, kif1.press_pulse, kif1.release_pulse, kif1.step_pulse};
      chk($sformatf("dut%0d.pressed", m), o[3], exp_prs[m][e]);
      chk($sformatf("dut%0d.press_pulse", m), o[2], exp_prp[m][e]);
      chk($sformatf("dut%0d.release_pulse", m), o[1], exp_rlp[m][e]);
      chk($sformatf("dut%0d.step_pulse", m), o[0], exp_stp[m][e]);
      chk($sformatf("dut%0d.exclusive", m), o[2] & o[1], 1'b0);
      if (o[2]) begin
        n_press[m]++;
        if (first_press[m] < 0) first_press[m] = e;
      end
      if (o[1]) begin
        n_rel[m]++;
        if (first_rel[m] < 0) begin
          first_rel[m]   = e;
          rel_pressed[m] = o[3];
        end
      end
      if (o[0]) begin
        n_step[m]++;
        if (m == 1) step_at1.push_back(e);
      end
      ever_pressed[m] |= o[3];
      all_pressed[m]  &= o[3];
    end
  endtask

  task automatic drive(input logic v, input int n);
    start_edge = e + 1;
    for (int i = 0; i < n; i++) begin
      key_n = v;
      tick();
    end
  endtask

  initial begin
    int offs [8];
    int t0, g, s, found;
    offs = '{0, 10, 13, 16, 19, 22, 25, 28};
    model_reset();
    clear_stats();

    // Reset held with the key released.
    #1;
    check_outputs_zero("in_reset");
    for (int i = 0; i < 3; i++) tick();
    aclr = 1'b1;
    clear_stats();
    drive(1'b1, 20);
    chk_int("idle_pulses", n_press[0] + n_press[1] + n_step[0] + n_step[1] + n_rel[0] + n_rel[1], 0);

    // Stable hold: single press on dut0, repeat train on dut1.
    clear_stats();
    drive(1'b0, 40);
    s  = start_edge;
    t0 = first_press[1];
    chk_int("norep_press_count", n_press[0], 1);
    chk_int("norep_step_count", n_step[0], 1);
    chk_int("norep_press_latency", first_press[0] - s, 7);
    chk_int("rep_press_count", n_press[1], 1);
    chk_int("rep_press_latency", t0 - s, 7);
    for (int i = 0; i < 8; i++) begin
      if (i < step_at1.size()) chk_int($sformatf("rep_step_offset%0d", i), step_at1[i] - t0, offs[i]);
      else chk_int($sformatf("rep_step_offset%0d", i), -1, offs[i]);
    end

    // Two-cycle release glitch while held.
    clear_stats();
    drive(1'b1, 2);
    g = start_edge;
    drive(1'b0, 25);
    chk_int("glitch_release_dut0", n_rel[0], 0);
    chk_int("glitch_release_dut1", n_rel[1], 0);
    chk("glitch_pressed_dut0", all_pressed[0], 1'b1);
    chk("glitch_pressed_dut1", all_pressed[1], 1'b1);
    found = -1;
    foreach (step_at1[i]) if (found < 0 && step_at1[i] > g + 2) found = step_at1[i];
    chk_int("glitch_next_repeat", found - g, 15);

    // Stable release.
    clear_stats();
    drive(1'b1, 20);
    s = start_edge;
    for (int m = 0; m < 2; m++) begin
      chk_int($sformatf("dut%0d.release_count", m), n_rel[m], 1);
      chk_int($sformatf("dut%0d.release_latency", m), first_rel[m] - s, 7);
      chk($sformatf("dut%0d.release_level", m), rel_pressed[m], 1'b0);
    end

    // Bounce: 3 low / 1 high never accepted.
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3);
      drive(1'b1, 1);
    end
    chk_int("bounce_pulses", n_press[0] + n_press[1] + n_step[0] + n_step[1], 0);
    chk("bounce_pressed", ever_pressed[0] | ever_pressed[1], 1'b0);

    // Reset while auto-repeating, key still held afterwards.
    clear_stats();
    drive(1'b0, 25);
    chk("pre_reset_pressed", kif1.pressed, 1'b1);
    #3;
    aclr = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("async_reset");
    for (int i = 0; i < 3; i++) tick();
    chk_int("reset_no_release", n_rel[0] + n_rel[1], 0);
    aclr = 1'b1;
    clear_stats();
    drive(1'b0, 15);
    s = start_edge;
    chk_int("repress_latency_dut0", first_press[0] - s, 7);
    chk_int("repress_latency_dut1", first_press[1] - s, 7);

    // Random key activity against the model.
    for (int c = 0; c < 700; ) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 6);
      drive(1'($urandom_range(0, 1)), len);
      c += len;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
